// File: rtl/zcted_timing_error_detector.sv
`default_nettype none
// ============================================================================
//  Module   : zcted_timing_error_detector
//  Purpose  : Zero-crossing (Gardner-style, sign-quantised) timing error
//             detector for a 2-samples-per-symbol symbol-timing loop.
//             Accepted interpolants alternate between on-time and mid-point
//             instants. On every on-time sample after the first, it emits
//               e = mid_I*(sgn(prev_I)-sgn(cur_I)) + mid_Q*(sgn(prev_Q)-sgn(cur_Q))
//             saturated to ERR_WIDTH bits, together with the on-time symbol.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset
//             I_interp   - signed in-phase interpolant
//             Q_interp   - signed quadrature interpolant
//             valid_in   - interpolant valid
//             strobe     - half-symbol instant marker (NCO underflow)
//             phase_flip - slip on-time/mid-point assignment by half a symbol
//             err_out    - signed timing error (held between pulses)
//             err_valid  - one-cycle qualifier for err_out
//             sym_I/sym_Q- on-time symbol samples (held between pulses)
//             sym_valid  - one-cycle qualifier for sym_I/sym_Q
//  Revision : 1.0 - initial release
// ============================================================================
module zcted_timing_error_detector #(
  parameter int DATA_WIDTH = 16,
  parameter int ERR_WIDTH  = DATA_WIDTH + 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] I_interp,
  input  logic signed [DATA_WIDTH-1:0] Q_interp,
  input  logic                         valid_in,
  input  logic                         strobe,
  input  logic                         phase_flip,
  output logic signed [ERR_WIDTH-1:0]  err_out,
  output logic                         err_valid,
  output logic signed [DATA_WIDTH-1:0] sym_I,
  output logic signed [DATA_WIDTH-1:0] sym_Q,
  output logic                         sym_valid
);

  // One guard bit above the output width holds the sum of two doubled terms.
  localparam int SUM_W = ERR_WIDTH + 1;

  localparam logic signed [ERR_WIDTH-1:0] ERR_MAX = {1'b0, {(ERR_WIDTH-1){1'b1}}};
  localparam logic signed [ERR_WIDTH-1:0] ERR_MIN = {1'b1, {(ERR_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    PRIME    = 2'd0,
    WAIT_MID = 2'd1,
    WAIT_ON  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  prev_i_q, prev_i_d;
  logic signed [DATA_WIDTH-1:0]  prev_q_q, prev_q_d;
  logic signed [DATA_WIDTH-1:0]  mid_i_q, mid_i_d;
  logic signed [DATA_WIDTH-1:0]  mid_q_q, mid_q_d;
  logic signed [ERR_WIDTH-1:0]   err_q, err_d;
  logic                          err_valid_q, err_valid_d;
  logic signed [DATA_WIDTH-1:0]  sym_i_q, sym_i_d;
  logic signed [DATA_WIDTH-1:0]  sym_q_q, sym_q_d;
  logic                          sym_valid_q, sym_valid_d;

  logic                          accept;
  logic signed [SUM_W-1:0]       term_i;
  logic signed [SUM_W-1:0]       term_q;
  logic signed [SUM_W-1:0]       err_sum;
  logic signed [ERR_WIDTH-1:0]   err_sat;

  assign accept = valid_in & strobe;

  // Sign difference sgn(prev)-sgn(cur) is +2, 0 or -2, so each product is
  // either zero or mid doubled (left shift) with the appropriate sign.
  function automatic logic signed [SUM_W-1:0] f_term(
    input logic signed [DATA_WIDTH-1:0] mid,
    input logic                         prev_neg,
    input logic                         cur_neg
  );
    logic signed [SUM_W-1:0] ext;
    logic signed [SUM_W-1:0] dbl;
    ext = {{(SUM_W-DATA_WIDTH){mid[DATA_WIDTH-1]}}, mid};
    dbl = {ext[SUM_W-2:0], 1'b0};
    if (!prev_neg && cur_neg) begin
      f_term = dbl;
    end else if (prev_neg && !cur_neg) begin
      f_term = -dbl;
    end else begin
      f_term = '0;
    end
  endfunction

  always_comb begin
    term_i  = f_term(mid_i_q, prev_i_q[DATA_WIDTH-1], I_interp[DATA_WIDTH-1]);
    term_q  = f_term(mid_q_q, prev_q_q[DATA_WIDTH-1], Q_interp[DATA_WIDTH-1]);
    err_sum = term_i + term_q;
    // Top two bits disagree only when the sum left the ERR_WIDTH range.
    if (err_sum[SUM_W-1] != err_sum[SUM_W-2]) begin
      err_sat = err_sum[SUM_W-1] ? ERR_MIN : ERR_MAX;
    end else begin
      err_sat = err_sum[ERR_WIDTH-1:0];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    prev_i_d    = prev_i_q;
    prev_q_d    = prev_q_q;
    mid_i_d     = mid_i_q;
    mid_q_d     = mid_q_q;
    err_d       = err_q;
    err_valid_d = 1'b0;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    sym_valid_d = 1'b0;

    if (phase_flip) begin
      // A slip re-anchors the symbol grid: a coincident sample becomes the
      // new on-time reference; otherwise wait for the next one.
      if (accept) begin
        prev_i_d    = I_interp;
        prev_q_d    = Q_interp;
        sym_i_d     = I_interp;
        sym_q_d     = Q_interp;
        sym_valid_d = 1'b1;
        state_d     = WAIT_MID;
      end else begin
        state_d = PRIME;
      end
    end else if (accept) begin
      unique case (state_q)
        PRIME: begin
          prev_i_d    = I_interp;
          prev_q_d    = Q_interp;
          sym_i_d     = I_interp;
          sym_q_d     = Q_interp;
          sym_valid_d = 1'b1;
          state_d     = WAIT_MID;
        end
        WAIT_MID: begin
          mid_i_d = I_interp;
          mid_q_d = Q_interp;
          state_d = WAIT_ON;
        end
        WAIT_ON: begin
          err_d       = err_sat;
          err_valid_d = 1'b1;
          prev_i_d    = I_interp;
          prev_q_d    = Q_interp;
          sym_i_d     = I_interp;
          sym_q_d     = Q_interp;
          sym_valid_d = 1'b1;
          state_d     = WAIT_MID;
        end
        default: begin
          state_d = PRIME;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PRIME;
      prev_i_q    <= '0;
      prev_q_q    <= '0;
      mid_i_q     <= '0;
      mid_q_q     <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_i_q    <= prev_i_d;
      prev_q_q    <= prev_q_d;
      mid_i_q     <= mid_i_d;
      mid_q_q     <= mid_q_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  assign err_out   = err_q;
  assign err_valid = err_valid_q;
  assign sym_I     = sym_i_q;
  assign sym_Q     = sym_q_q;
  assign sym_valid = sym_valid_q;

endmodule
`default_nettype wire

// File: doc/zcted_timing_error_detector.md
ZCTED_TIMING_ERROR_DETECTOR -- requirements
Module: zcted_timing_error_detector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of signed interpolant inputs and symbol outputs.
REQ-002 SHALL have parameter ERR_WIDTH, default DATA_WIDTH+2 (18): width of the signed timing-error output.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port I_interp  input  DATA_WIDTH  signed in-phase interpolant from the upstream interpolator.
REQ-006 SHALL have port Q_interp  input  DATA_WIDTH  signed quadrature interpolant.
REQ-007 SHALL have port valid_in  input  1  interpolator output valid.
REQ-008 SHALL have port strobe  input  1  NCO underflow; marks the current interpolant as a half-symbol instant.
REQ-009 SHALL have port phase_flip  input  1  single-cycle request to slip the on-time/mid-point assignment by half a symbol.
REQ-010 SHALL have port err_out  output  ERR_WIDTH  signed timing error to the loop filter.
REQ-011 SHALL have port err_valid  output  1  one-cycle pulse qualifying err_out.
REQ-012 SHALL have port sym_I, sym_Q  output  DATA_WIDTH each  signed on-time symbol decision samples.
REQ-013 SHALL have port sym_valid  output  1  one-cycle pulse qualifying sym_I/sym_Q.

Function
REQ-014 A sample SHALL be accepted only in a cycle with valid_in=1 and strobe=1; all other cycles leave the state and stored samples unchanged.
REQ-015 FSM SHALL have states PRIME (await first on-time sample), WAIT_MID (next accept is mid-point), and WAIT_ON (next accept is on-time).
REQ-016 In PRIME, an accept SHALL store the sample as prev_on and move to WAIT_MID, with no err_valid and with sym_valid pulsed.
REQ-017 In WAIT_MID, an accept SHALL store the sample as mid and move to WAIT_ON, with no output pulses.
REQ-018 In WAIT_ON, an accept SHALL compute the error, pulse err_valid and sym_valid, copy the sample into prev_on, and move to WAIT_MID.
REQ-019 The error SHALL be mid_I*(sgn(prev_I)-sgn(cur_I)) + mid_Q*(sgn(prev_Q)-sgn(cur_Q)), with sgn(x)=+1 for x>=0 and -1 for x<0; each difference is therefore in {-2,0,+2}.
REQ-020 Each product term SHALL be formed as 0 or a signed one-bit left shift of mid, sign-extended to ERR_WIDTH+1; no multiplier is used.
REQ-021 The sum SHALL saturate to the ERR_WIDTH signed range; the only overflow case, +131072 at defaults (mid=-32768 with both differences -2), SHALL yield +131071.
REQ-022 Latency SHALL be exactly one cycle: outputs and pulses are registered in the clock edge following the accepting edge.
REQ-023 sym_I/sym_Q SHALL carry the accepted on-time sample and SHALL hold their value between sym_valid pulses.
REQ-024 err_out SHALL hold its last value between err_valid pulses.
REQ-025 phase_flip SHALL take priority over REQ-016..018. Any sample accepted in the same cycle becomes prev_on and the state moves to WAIT_MID, with no err_valid and sym_valid pulsed. Without an accept, the state moves to PRIME.
REQ-026 Back-to-back accepts on consecutive cycles SHALL be supported with no dropped samples.

Reset
REQ-027 While rst_n=0, asynchronously: state=PRIME; prev_on and mid=0; err_out=0, err_valid=0, sym_I=0, sym_Q=0, sym_valid=0.
REQ-028 Reset asserted mid-symbol SHALL discard the partial history; after release, the first accept is treated as on-time per REQ-016.
REQ-029 Inputs SHALL be ignored in the cycle of rst_n deassertion if that edge coincides with rst_n still low at sampling.

Verification
REQ-030 Reset: hold rst_n=0 with strobe/valid_in toggling -> all outputs 0, no pulses; after release, the first accept (I=100) -> sym_valid with sym_I=100, no err_valid.
REQ-031 Zero crossing: accept on-time I=+1000, mid I=+300, on-time I=-1000, with Q=0 throughout -> err_out=+600 one cycle later, err_valid for 1 cycle.
REQ-032 No crossing: on-time +1000, mid +300, on-time +900, with Q=0 -> err_out=0, err_valid=1.
REQ-033 Saturation: prev I/Q=-1, mid I/Q=-32768, current I/Q=+1 -> err_out=+131071.
REQ-034 Gating: strobe=1 with valid_in=0, or valid_in=1 with strobe=0 -> no state change, no pulses.
REQ-035 phase_flip: assert in WAIT_ON together with an accept of I=500 -> no err_valid, sym_I=500; the next two accepts are handled as mid then on-time.
